// File: rtl/voice_scheduler_pkg.sv
// voice_scheduler_pkg
//  Shared definitions for the chord voice scheduler:
//   - default sizes for NUM_VOICES, NOTE_W and DUR_W
//   - REST_NOTE: the note code that means "silence"
//   - AGE_W: width of the per-voice saturating age counters
//   - state_t: scheduler FSM states (IDLE, LOAD)
package voice_scheduler_pkg;

  localparam int NUM_VOICES_DEF = 3;
  localparam int NOTE_W_DEF     = 6;
  localparam int DUR_W_DEF      = 6;
  localparam int REST_NOTE      = 0;
  localparam int AGE_W          = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/voice_scheduler_if.sv
// voice_scheduler_if
//  Note stream from the song reader into the scheduler.
//  Signals:
//   note_in      note code (0 = rest)
//   duration_in  duration in beats
//   note_valid   producer holds note_in/duration_in valid
//   note_ready   consumer can take the note this cycle
//  Handshake: a transfer happens on a rising clk edge where note_valid and
//  note_ready are both high. Once note_valid is raised the producer keeps
//  note_in/duration_in stable until that transfer; note_ready may rise and
//  fall freely and never depends combinationally on note_valid.
//  Modports: master = song reader, slave = scheduler.
interface voice_scheduler_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
);
  logic [NOTE_W-1:0] note_in;
  logic [DUR_W-1:0]  duration_in;
  logic              note_valid;
  logic              note_ready;

  modport master (output note_in, output duration_in, output note_valid, input note_ready);
  modport slave  (input note_in, input duration_in, input note_valid, output note_ready);
endinterface

// File: rtl/voice_scheduler_rr_picker.sv
// voice_scheduler_rr_picker
//  Combinational round-robin priority encoder. Scans free_mask starting at
//  index ptr and wrapping, and grants the first set bit.
//  Ports:
//   free_mask     in   N      candidate voices
//   ptr           in   IDX_W  index where the search starts
//   grant_onehot  out  N      one-hot grant (0 when nothing is free)
//   grant_idx     out  IDX_W  binary index of the grant
//   any           out  1      at least one candidate was found
module voice_scheduler_rr_picker #(
  parameter  int N     = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     free_mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    int idx;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    idx          = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && free_mask[idx]) begin
        any               = 1'b1;
        grant_idx         = IDX_W'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler
//  Allocates notes from the song reader to NUM_VOICES note_player voices.
//  A voice is free when its done flag is high and it is not pending (loaded
//  but its done flag has not yet been seen low). Free voices are picked
//  round-robin starting one past the last loaded voice.
//  Optional feature macro: VOICE_STEAL_EN -- when no voice is free, the
//  oldest busy voice (largest age, lowest index on ties) is reallocated and
//  steal_pulse fires. Without it, note_ready waits for a free voice.
//  Ports:
//   clk, reset      clock, asynchronous active-low reset
//   play            playback enable; low blocks new acceptances
//   note_if         slave side of the note stream (valid/ready)
//   voice_done      per-voice done_with_note from the note_players
//   load_voice      one-hot, 1-cycle load strobe
//   note_out        registered note, stable while load_voice is high
//   duration_out    registered duration, stable while load_voice is high
//   active_count    registered number of busy voices
//   steal_pulse     1-cycle pulse when a busy voice is reallocated
//   fsm_state       current FSM state (debug)
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter  int NUM_VOICES = NUM_VOICES_DEF,
  parameter  int NOTE_W     = NOTE_W_DEF,
  parameter  int DUR_W      = DUR_W_DEF,
  localparam int CNT_W      = $clog2(NUM_VOICES + 1),
  localparam int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  voice_scheduler_if.slave      note_if,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] load_voice,
  output logic [NOTE_W-1:0]     note_out,
  output logic [DUR_W-1:0]      duration_out,
  output logic [CNT_W-1:0]      active_count,
  output logic                  steal_pulse,
  output state_t                fsm_state
);

  state_t                state;
  logic [NUM_VOICES-1:0] pending;
  logic [NUM_VOICES-1:0] free_mask;
  logic [NUM_VOICES-1:0] busy;
  logic [NUM_VOICES-1:0] pick_oh;
  logic [NUM_VOICES-1:0] grant_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      next_ptr;
  logic [IDX_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]      busy_cnt;
  logic                  any_free;
  logic                  steal_ok;
  logic                  accept;
  logic                  is_rest;

  // A done flag rising in the accept cycle makes that voice free right away.
  assign free_mask = voice_done & ~pending;
  assign busy      = ~voice_done | pending;
  assign fsm_state = state;

  voice_scheduler_rr_picker #(.N(NUM_VOICES)) u_picker (
    .free_mask    (free_mask),
    .ptr          (rr_ptr),
    .grant_onehot (pick_oh),
    .grant_idx    (pick_idx),
    .any          (any_free)
  );

`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0]      age [NUM_VOICES];
  logic [NUM_VOICES-1:0] old_oh;
  logic [IDX_W-1:0]      old_idx;
  logic [AGE_W-1:0]      best_age;
  logic                  found;

  // Oldest non-free voice; strict '>' keeps the lowest index on ties.
  always_comb begin
    old_oh   = '0;
    old_idx  = '0;
    best_age = '0;
    found    = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!free_mask[v] && (!found || age[v] > best_age)) begin
        found     = 1'b1;
        best_age  = age[v];
        old_idx   = IDX_W'(v);
        old_oh    = '0;
        old_oh[v] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VOICES; v++) age[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (load_voice[v])
          age[v] <= '0;
        else if (!voice_done[v] && age[v] != {AGE_W{1'b1}})
          age[v] <= age[v] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      steal_pulse <= 1'b0;
    else
      steal_pulse <= (state == IDLE) && accept && !is_rest && !any_free;
  end

  assign steal_ok  = 1'b1;
  assign grant_oh  = any_free ? pick_oh  : old_oh;
  assign grant_idx = any_free ? pick_idx : old_idx;
`else
  assign steal_ok    = 1'b0;
  assign steal_pulse = 1'b0;
  assign grant_oh    = pick_oh;
  assign grant_idx   = pick_idx;
`endif

  assign note_if.note_ready = play && (state == IDLE) && (any_free || steal_ok);
  assign accept             = note_if.note_valid && note_if.note_ready;
  assign is_rest            = (note_if.note_in == NOTE_W'(REST_NOTE));
  assign next_ptr           = (grant_idx == IDX_W'(NUM_VOICES - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    busy_cnt = '0;
    for (int v = 0; v < NUM_VOICES; v++) busy_cnt = busy_cnt + CNT_W'(busy[v]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      load_voice   <= '0;
      note_out     <= '0;
      duration_out <= '0;
      rr_ptr       <= '0;
    end else begin
      load_voice <= '0;
      case (state)
        IDLE: begin
          // Rests are consumed here without touching voices or the pointer.
          if (accept && !is_rest) begin
            note_out     <= note_if.note_in;
            duration_out <= note_if.duration_in;
            load_voice   <= grant_oh;
            rr_ptr       <= next_ptr;
            state        <= LOAD;
          end
        end
        LOAD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pending bridges the gap between the strobe and the note_player
  // dropping its done flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending      <= '0;
      active_count <= '0;
    end else begin
      pending      <= (pending & voice_done) | load_voice;
      active_count <= busy_cnt;
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler
//  Directed bench for voice_scheduler (3 voices, 6-bit note/duration).
//  Inputs change on the falling clock edge; outputs are sampled 1 time unit
//  after it. Build with VOICE_STEAL_EN defined to exercise voice stealing.
module tb_voice_scheduler;
  import voice_scheduler_pkg::*;

  logic       clk;
  logic       reset;
  logic       play;
  logic [2:0] voice_done;
  logic [2:0] load_voice;
  logic [5:0] note_out;
  logic [5:0] duration_out;
  logic [1:0] active_count;
  logic       steal_pulse;
  state_t     fsm_state;

  int errors = 0;
  int checks = 0;

  voice_scheduler_if #(.NOTE_W(6), .DUR_W(6)) nif ();

  voice_scheduler #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .note_if      (nif),
    .voice_done   (voice_done),
    .load_voice   (load_voice),
    .note_out     (note_out),
    .duration_out (duration_out),
    .active_count (active_count),
    .steal_pulse  (steal_pulse),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset          = 1'b0;
    play           = 1'b1;
    voice_done     = 3'b111;
    nif.note_valid = 1'b0;
    nif.note_in    = '0;
    nif.duration_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  // Holds a note valid until it is taken; returns 1 time unit after the
  // falling edge that follows the accepting rising edge.
  task automatic send_note(input logic [5:0] n, input logic [5:0] d);
    int waited;
    waited          = 0;
    nif.note_in     = n;
    nif.duration_in = d;
    nif.note_valid  = 1'b1;
    #1;
    while (!nif.note_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("accept_wait", 32'(waited < 20), 32'd1);
    @(negedge clk);
    nif.note_valid = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    check("rst_load",   load_voice,     32'h0);
    check("rst_note",   note_out,       32'h0);
    check("rst_dur",    duration_out,   32'h0);
    check("rst_active", active_count,   32'h0);
    check("rst_steal",  steal_pulse,    32'h0);
    check("rst_state",  fsm_state,      32'(IDLE));
    check("rst_ready",  nif.note_ready, 32'h1);

    // chord of three notes, each voice drops done after its strobe
    send_note(6'd12, 6'd4);
    check("t1_load0", load_voice,   32'h1);
    check("t1_note0", note_out,     32'd12);
    check("t1_dur0",  duration_out, 32'd4);
    check("t1_state", fsm_state,    32'(LOAD));
    voice_done[0] = 1'b0;
    send_note(6'd16, 6'd4);
    check("t1_load1", load_voice, 32'h2);
    check("t1_note1", note_out,   32'd16);
    voice_done[1] = 1'b0;
    send_note(6'd19, 6'd4);
    check("t1_load2", load_voice, 32'h4);
    check("t1_note2", note_out,   32'd19);
    voice_done[2] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("t1_active", active_count, 32'd3);

`ifndef VOICE_STEAL_EN
    // all busy: the note waits until voice 1 reports done
    nif.note_in     = 6'd24;
    nif.duration_in = 6'd3;
    nif.note_valid  = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t2_blocked", nif.note_ready, 32'h0);
      @(negedge clk);
      #1;
    end
    voice_done[1] = 1'b1;
    #1;
    check("t2_ready", nif.note_ready, 32'h1);
    @(negedge clk);
    nif.note_valid = 1'b0;
    #1;
    check("t2_load",  load_voice,   32'h2);
    check("t2_note",  note_out,     32'd24);
    check("t2_dur",   duration_out, 32'd3);
    check("t2_steal", steal_pulse,  32'h0);
    voice_done[1] = 1'b0;
`else
    // steal: load all voices, then age them 5/9/2 with voice 1 oldest
    do_reset();
    send_note(6'd12, 6'd4);
    check("t3_load0", load_voice, 32'h1);
    send_note(6'd16, 6'd4);
    check("t3_load1", load_voice, 32'h2);
    send_note(6'd19, 6'd4);
    check("t3_load2", load_voice, 32'h4);
    repeat (2) @(negedge clk);
    #1;
    check("t3_active", active_count, 32'd3);
    voice_done[1] = 1'b0;
    repeat (4) @(negedge clk);
    voice_done[0] = 1'b0;
    repeat (3) @(negedge clk);
    voice_done[2] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("t3_ready", nif.note_ready, 32'h1);
    send_note(6'd31, 6'd5);
    check("t3_load",  load_voice,  32'h2);
    check("t3_steal", steal_pulse, 32'h1);
    check("t3_note",  note_out,    32'd31);
    @(negedge clk);
    #1;
    check("t3_steal_end", steal_pulse, 32'h0);
    check("t3_load_end",  load_voice,  32'h0);
`endif

    // rest is consumed without a strobe and leaves the pointer alone
    do_reset();
    send_note(6'd0, 6'd2);
    check("t4_rest_load",  load_voice,     32'h0);
    check("t4_rest_state", fsm_state,      32'(IDLE));
    check("t4_rest_note",  note_out,       32'h0);
    check("t4_rest_ready", nif.note_ready, 32'h1);
    send_note(6'd20, 6'd4);
    check("t4_load0", load_voice, 32'h1);
    send_note(6'd22, 6'd4);
    check("t4_load1", load_voice, 32'h2);
    repeat (2) @(negedge clk);
    #1;
    check("t4_active", active_count, 32'd2);

    // reset in the middle of a LOAD cycle
    send_note(6'd25, 6'd6);
    check("t5_load", load_voice, 32'h4);
    reset = 1'b0;
    #1;
    check("t5_load_drop", load_voice, 32'h0);
    check("t5_state",     fsm_state,  32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_ready",  nif.note_ready, 32'h1);
    check("t5_active", active_count,   32'h0);

    // play gates acceptance
    play            = 1'b0;
    nif.note_in     = 6'd30;
    nif.duration_in = 6'd7;
    nif.note_valid  = 1'b1;
    #1;
    check("t6_noplay0", nif.note_ready, 32'h0);
    @(negedge clk);
    #1;
    check("t6_noplay1", nif.note_ready, 32'h0);
    check("t6_noload",  load_voice,     32'h0);
    play = 1'b1;
    #1;
    check("t6_ready", nif.note_ready, 32'h1);
    @(negedge clk);
    nif.note_valid = 1'b0;
    #1;
    check("t6_load", load_voice, 32'h1);
    check("t6_note", note_out,   32'd30);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
